// File: rtl/instr_packer.sv
// Streaming instruction packer: range-checks decoded fields, packs an 8-bit word and
// queues it with a sequential program address in a 2-entry output buffer.
module instr_packer #(
  parameter int unsigned n  = 8,
  parameter int unsigned AW = 5
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [1:0]    in_rf,
  input  logic [n-1:0]  in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_instr,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    err_count,
  output logic [2:0]    err_last_op,
  output logic          wrapped
);

  // Opcode values mirror the core's opcodes.sv macros.
  localparam logic [2:0] OP_ADDI = 3'd0;
  localparam logic [2:0] OP_SLLI = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_J    = 3'd4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state, state_nx;
  logic            legal_c, accept_c, push_c, pop_c, reject_c;
  logic            head_new_c, head_from_tail_c, tail_new_c;
  logic [n-1:0]    word_c;
  logic [n-1:0]    tail_instr;
  logic [AW-1:0]   tail_addr;
  logic [AW-1:0]   next_addr;
  logic [AW-1:0]   addr_base_c;
  logic [7:0]      err_base_c;

  // Range check on the full immediate and word assembly.
  always_comb begin
    legal_c = 1'b1;
    word_c  = {in_op, in_rf, in_imm[2:0]};
    case (in_op)
      OP_ADDI:               legal_c = (&in_imm[n-1:2]) || (~|in_imm[n-1:2]);
      OP_SLLI, OP_BLT, OP_BEQ: legal_c = ~|in_imm[n-1:3];
      OP_J: begin
        legal_c = (&in_imm[n-1:4]) || (~|in_imm[n-1:4]);
        word_c  = {in_op, in_imm[4:0]};
      end
      default: ;
    endcase
  end

  assign accept_c    = in_valid && in_ready;
  assign push_c      = accept_c && legal_c;
  assign reject_c    = accept_c && !legal_c;
  assign pop_c       = out_valid && out_ready;
  assign addr_base_c = start ? '0 : next_addr;
  assign err_base_c  = start ? 8'd0 : err_count;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= EMPTY;
    else         state <= state_nx;
  end

  // Buffer occupancy and which storage slot loads this cycle.
  always_comb begin
    state_nx         = state;
    head_new_c       = 1'b0;
    head_from_tail_c = 1'b0;
    tail_new_c       = 1'b0;
    case (state)
      EMPTY: if (push_c) begin
        state_nx   = ONE;
        head_new_c = 1'b1;
      end
      ONE: begin
        if (push_c && pop_c) begin
          head_new_c = 1'b1;
        end else if (push_c) begin
          state_nx   = FULL;
          tail_new_c = 1'b1;
        end else if (pop_c) begin
          state_nx = EMPTY;
        end
      end
      FULL: if (pop_c) begin
        state_nx         = ONE;
        head_from_tail_c = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= '0;
      tail_instr <= '0;
      tail_addr  <= '0;
    end else begin
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
      if (head_new_c) begin
        out_instr <= word_c;
        out_addr  <= addr_base_c;
      end else if (head_from_tail_c) begin
        out_instr <= tail_instr;
        out_addr  <= tail_addr;
      end
      if (tail_new_c) begin
        tail_instr <= word_c;
        tail_addr  <= addr_base_c;
      end
    end
  end

  // Address counter and error bookkeeping; start takes effect before the accept.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      next_addr   <= '0;
      wrapped     <= 1'b0;
      err_count   <= 8'd0;
      err_last_op <= 3'd0;
    end else begin
      next_addr <= push_c ? addr_base_c + AW'(1) : addr_base_c;
      wrapped   <= (start ? 1'b0 : wrapped) | (push_c && (&addr_base_c));
      if (reject_c) begin
        err_count   <= (&err_base_c) ? err_base_c : err_base_c + 8'd1;
        err_last_op <= in_op;
      end else begin
        err_count   <= err_base_c;
        err_last_op <= start ? 3'd0 : err_last_op;
      end
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer with hand-computed expected words.
module tb_instr_packer;

  localparam logic [2:0] ADDI = 3'd0;
  localparam logic [2:0] SLLI = 3'd1;
  localparam logic [2:0] BLT  = 3'd2;
  localparam logic [2:0] BEQ  = 3'd3;
  localparam logic [2:0] J    = 3'd4;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0;
  logic [1:0] in_rf = 2'd0;
  logic [7:0] in_imm = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [4:0] out_addr;
  logic [7:0] err_count;
  logic [2:0] err_last_op;
  logic       wrapped;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] popq[$];

  instr_packer #(.n(8), .AW(5)) dut (
    .Clock(Clock), .nReset(nReset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rf(in_rf), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_count(err_count), .err_last_op(err_last_op), .wrapped(wrapped)
  );

  always #5 Clock = ~Clock;

  // Record every word the consumer takes as {addr, instr}.
  always @(posedge Clock)
    if (nReset && out_valid && out_ready) popq.push_back({out_addr, out_instr});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] immgen(input logic [7:0] w);
    case (w[7:5])
      J:    immgen = {{3{w[4]}}, w[4:0]};
      ADDI: immgen = {{5{w[2]}}, w[2:0]};
      default: immgen = {5'd0, w[2:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rf, input logic [7:0] imm);
    int t = 0;
    in_op = op; in_rf = rf; in_imm = imm; in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    chk("send_ready", 32'(t < 20), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [12:0] e;
    // Reset values
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_last_op", 32'(err_last_op), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    nReset = 1'b1;
    tick();

    // First word: ADDI rf=2 imm=-4
    out_ready = 1'b1;
    send(ADDI, 2'd2, 8'hFC);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", 32'(out_instr), 32'h14);
    chk("t1_addr", 32'(out_addr), 32'd0);
    tick();
    chk("t1_popped", 32'(out_valid), 32'd0);

    // Three unencodable immediates
    pulse_start();
    popq.delete();
    send(ADDI, 2'd0, 8'h04);
    send(SLLI, 2'd0, 8'hFF);
    send(J, 2'd0, 8'h10);
    chk("t2_err_count", 32'(err_count), 32'd3);
    chk("t2_last_op", 32'(err_last_op), 32'(J));
    chk("t2_no_valid", 32'(out_valid), 32'd0);
    send(J, 2'd3, 8'hF0);
    send(BEQ, 2'd1, 8'h07);
    tick(); tick();
    chk("t3_count", 32'(popq.size()), 32'd2);
    if (popq.size() == 2) begin
      e = {5'd0, 8'h90};
      chk("t3_j_word", 32'(popq[0]), 32'(e));
      e = {5'd1, 8'h6F};
      chk("t3_beq_word", 32'(popq[1]), 32'(e));
      chk("t3_rt_j", 32'(immgen(popq[0][7:0])), 32'hF0);
      chk("t3_rt_beq", 32'(immgen(popq[1][7:0])), 32'h07);
    end

    // Backpressure: fill buffer, then drain with an overlapping push
    out_ready = 1'b0;
    pulse_start();
    popq.delete();
    send(SLLI, 2'd0, 8'h01);
    chk("t4_ready_one", 32'(in_ready), 32'd1);
    send(BLT, 2'd3, 8'h05);
    chk("t4_ready_full", 32'(in_ready), 32'd0);
    tick();
    chk("t4_hold_addr", 32'(out_addr), 32'd0);
    chk("t4_hold_instr", 32'(out_instr), 32'h21);
    in_op = 3'd7; in_rf = 2'd1; in_imm = 8'hAA; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t4_ready_back", 32'(in_ready), 32'd1);
    chk("t4_head2_addr", 32'(out_addr), 32'd1);
    chk("t4_head2_instr", 32'(out_instr), 32'h5D);
    tick();
    in_valid = 1'b0;
    chk("t4_head3_addr", 32'(out_addr), 32'd2);
    chk("t4_head3_instr", 32'(out_instr), 32'hEA);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);
    chk("t4_pop_count", 32'(popq.size()), 32'd3);
    if (popq.size() == 3) begin
      e = {5'd0, 8'h21};
      chk("t4_order0", 32'(popq[0]), 32'(e));
      e = {5'd1, 8'h5D};
      chk("t4_order1", 32'(popq[1]), 32'(e));
      e = {5'd2, 8'hEA};
      chk("t4_order2", 32'(popq[2]), 32'(e));
    end

    // Address wrap over 33 words at full throughput
    pulse_start();
    for (int i = 0; i < 33; i++) begin
      chk("t5_wrap_pre", 32'(wrapped), 32'(i >= 32));
      send(SLLI, 2'd0, 8'(i % 8));
      chk("t5_addr", 32'(out_addr), 32'(i % 32));
      chk("t5_instr", 32'(out_instr), 32'({SLLI, 2'b00, 3'(i % 8)}));
    end
    chk("t5_wrapped", 32'(wrapped), 32'd1);
    start = 1'b1;
    in_op = ADDI; in_rf = 2'd1; in_imm = 8'h03; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("t5_start_addr", 32'(out_addr), 32'd0);
    chk("t5_start_instr", 32'(out_instr), 32'h0B);
    chk("t5_start_wrapped", 32'(wrapped), 32'd0);
    send(BEQ, 2'd0, 8'h00);
    chk("t5_after_start", 32'(out_addr), 32'd1);

    // start together with an illegal set
    send(ADDI, 2'd0, 8'h7F);
    chk("t5_err_pre", 32'(err_count), 32'd1);
    start = 1'b1;
    in_op = BLT; in_rf = 2'd0; in_imm = 8'h08; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("t5_start_err", 32'(err_count), 32'd1);
    chk("t5_start_lastop", 32'(err_last_op), 32'(BLT));

    // Error count saturation
    pulse_start();
    for (int i = 0; i < 260; i++) send(J, 2'd0, 8'h40);
    chk("t6_saturate", 32'(err_count), 32'd255);

    // Asynchronous reset with a full buffer
    pulse_start();
    for (int i = 0; i < 5; i++) send(ADDI, 2'd0, 8'h80);
    chk("t7_err5", 32'(err_count), 32'd5);
    out_ready = 1'b0;
    send(SLLI, 2'd2, 8'h02);
    send(SLLI, 2'd2, 8'h03);
    chk("t7_full", 32'(in_ready), 32'd0);
    #3 nReset = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_err", 32'(err_count), 32'd0);
    chk("t7_rst_ready", 32'(in_ready), 32'd1);
    nReset = 1'b1;
    tick();
    out_ready = 1'b1;
    send(BEQ, 2'd2, 8'h06);
    chk("t7_addr0", 32'(out_addr), 32'd0);
    chk("t7_instr", 32'(out_instr), 32'h76);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
